// File: rtl/csr_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_router_pkg
// Description : Shared types and constants for the CSR address router:
//               FSM state encoding, error response words and the port-index
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_router_pkg;

  // Router transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Read data returned when the port index does not map to a port
  localparam logic [31:0] RESP_BADADD  = 32'hBADADD00;
  // Read data returned when a downstream port never releases waitrequest
  localparam logic [31:0] RESP_TIMEOUT = 32'hDEADC0DE;

  // Width of the port-index field; a single port still uses one bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : csr_timeout_counter
// Description : Stall watchdog. load clears the count, enable advances it,
//               expire flags the final allowed stalled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count stalled cycles since the last load, holding at the final value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The TIMEOUT-th stalled cycle is the last one the strobe is held for
  assign expire_o = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/csr_address_router.sv
`default_nettype none
// ============================================================================
// Module      : csr_address_router
// Description : Single-outstanding Avalon-MM CSR router. Decodes the upstream
//               word address into a port index and a port-local address,
//               forwards one command at a time, and reports decode, protocol
//               and timeout errors through sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_address_router
  import csr_router_pkg::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int PORT_ADDR_W  = 11,
  parameter int SLAVE_ADDR_W = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                             csr_clk_clk,
  input  logic                             csr_clk_reset_reset,
  input  logic [SLAVE_ADDR_W-1:0]          slave_address,
  input  logic                             slave_read,
  input  logic                             slave_write,
  input  logic [31:0]                      slave_writedata,
  output logic [31:0]                      slave_readdata,
  output logic                             slave_waitrequest,
  output logic [NUM_PORTS*PORT_ADDR_W-1:0] m_address,
  output logic [NUM_PORTS-1:0]             m_read,
  output logic [NUM_PORTS-1:0]             m_write,
  output logic [31:0]                      m_writedata,
  input  logic [NUM_PORTS*32-1:0]          m_readdata,
  input  logic [NUM_PORTS-1:0]             m_waitrequest,
  input  logic                             err_clear,
  output logic                             err_timeout,
  output logic                             err_decode,
  output logic                             err_proto,
  output logic [7:0]                       timeout_count
);

  localparam int IDX_W = idx_w(NUM_PORTS);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic                 write_q;
  logic [NUM_PORTS-1:0] m_read_q, m_write_q;
  logic [31:0]          m_writedata_q;
  logic [31:0]          rdata_q;
  logic                 wait_q;
  logic                 err_timeout_q, err_decode_q, err_proto_q;
  logic [7:0]           tcount_q;

  logic [IDX_W-1:0]     w_idx;
  logic                 w_dec_ok;
  logic                 w_cmd;
  logic                 w_accept;
  logic                 w_stall;
  logic                 w_ack;
  logic                 w_expire;
  logic                 w_timeout;
  logic [NUM_PORTS-1:0] w_onehot;
  logic [31:0]          w_rdata_sel;
  logic                 w_unused_addr;

  assign w_idx    = slave_address[PORT_ADDR_W +: IDX_W];
  assign w_dec_ok = (int'(w_idx) < NUM_PORTS);
  assign w_cmd    = slave_read | slave_write;
  assign w_accept = (state_q == IDLE) && w_cmd;
  assign w_ack    = (state_q == ISSUE) && !w_stall;
  assign w_timeout = w_expire;

  // Address bits above the port index are deliberately ignored
  assign w_unused_addr = &{1'b0, slave_address};

  // Port-select decode for the incoming index and mux for the latched index
  always_comb begin
    w_onehot    = '0;
    w_rdata_sel = '0;
    w_stall     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_onehot[k] = (w_idx == IDX_W'(k));
      if (idx_q == IDX_W'(k)) begin
        w_rdata_sel = m_readdata[k*32 +: 32];
        w_stall     = m_waitrequest[k];
      end
    end
  end

  csr_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (csr_clk_clk),
    .rst_i    (csr_clk_reset_reset),
    .load_i   (w_accept),
    .en_i     ((state_q == ISSUE) && w_stall),
    .expire_o (w_expire)
  );

  // State register
  always_ff @(posedge csr_clk_clk or posedge csr_clk_reset_reset) begin
    if (csr_clk_reset_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unmapped indices skip straight to the response phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_cmd) state_d = w_dec_ok ? ISSUE : DONE;
      ISSUE:   if (w_ack || w_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction datapath: latch command, drive strobes, capture response
  always_ff @(posedge csr_clk_clk or posedge csr_clk_reset_reset) begin
    if (csr_clk_reset_reset) begin
      idx_q         <= '0;
      write_q       <= 1'b0;
      m_read_q      <= '0;
      m_write_q     <= '0;
      m_writedata_q <= '0;
      rdata_q       <= '0;
      wait_q        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_cmd) begin
            idx_q   <= w_idx;
            // A simultaneous read and write is resolved as a write
            write_q <= slave_write;
            if (w_dec_ok) begin
              m_read_q  <= slave_write ? '0 : w_onehot;
              m_write_q <= slave_write ? w_onehot : '0;
              if (slave_write) begin
                m_writedata_q <= slave_writedata;
              end
            end else begin
              wait_q  <= 1'b0;
              rdata_q <= slave_write ? 32'h0 : RESP_BADADD;
            end
          end
        end
        ISSUE: begin
          if (w_ack) begin
            m_read_q  <= '0;
            m_write_q <= '0;
            wait_q    <= 1'b0;
            rdata_q   <= write_q ? 32'h0 : w_rdata_sel;
          end else if (w_timeout) begin
            m_read_q  <= '0;
            m_write_q <= '0;
            wait_q    <= 1'b0;
            rdata_q   <= RESP_TIMEOUT;
          end
        end
        DONE: begin
          wait_q <= 1'b1;
        end
        default: begin
          m_read_q  <= '0;
          m_write_q <= '0;
          wait_q    <= 1'b1;
        end
      endcase
    end
  end

  // Sticky error flags and saturating timeout counter; clear wins over set
  always_ff @(posedge csr_clk_clk or posedge csr_clk_reset_reset) begin
    if (csr_clk_reset_reset) begin
      err_timeout_q <= 1'b0;
      err_decode_q  <= 1'b0;
      err_proto_q   <= 1'b0;
      tcount_q      <= '0;
    end else if (err_clear) begin
      err_timeout_q <= 1'b0;
      err_decode_q  <= 1'b0;
      err_proto_q   <= 1'b0;
      tcount_q      <= '0;
    end else begin
      if (w_accept && !w_dec_ok) begin
        err_decode_q <= 1'b1;
      end
      if (w_accept && slave_read && slave_write) begin
        err_proto_q <= 1'b1;
      end
      if (w_timeout) begin
        err_timeout_q <= 1'b1;
        if (tcount_q != 8'hFF) begin
          tcount_q <= tcount_q + 8'd1;
        end
      end
    end
  end

  // Per-port address registers hold their last target address between accesses
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [PORT_ADDR_W-1:0] addr_q;

    // Capture the port-local address only when this port is the accepted target
    always_ff @(posedge csr_clk_clk or posedge csr_clk_reset_reset) begin
      if (csr_clk_reset_reset) begin
        addr_q <= '0;
      end else if (w_accept && w_dec_ok && w_onehot[k]) begin
        addr_q <= slave_address[PORT_ADDR_W-1:0];
      end
    end

    assign m_address[k*PORT_ADDR_W +: PORT_ADDR_W] = addr_q;
  end

  assign m_read            = m_read_q;
  assign m_write           = m_write_q;
  assign m_writedata       = m_writedata_q;
  assign slave_readdata    = rdata_q;
  assign slave_waitrequest = wait_q;
  assign err_timeout       = err_timeout_q;
  assign err_decode        = err_decode_q;
  assign err_proto         = err_proto_q;
  assign timeout_count     = tcount_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_address_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_address_router
// Description : Directed self-checking bench for csr_address_router with
//               NUM_PORTS=3, PORT_ADDR_W=11, SLAVE_ADDR_W=16, TIMEOUT=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_address_router;

  localparam int NUM_PORTS    = 3;
  localparam int PORT_ADDR_W  = 11;
  localparam int SLAVE_ADDR_W = 16;
  localparam int TIMEOUT      = 16;

  logic                             clk;
  logic                             rst;
  logic [SLAVE_ADDR_W-1:0]          slave_address;
  logic                             slave_read;
  logic                             slave_write;
  logic [31:0]                      slave_writedata;
  logic [31:0]                      slave_readdata;
  logic                             slave_waitrequest;
  logic [NUM_PORTS*PORT_ADDR_W-1:0] m_address;
  logic [NUM_PORTS-1:0]             m_read;
  logic [NUM_PORTS-1:0]             m_write;
  logic [31:0]                      m_writedata;
  logic [NUM_PORTS*32-1:0]          m_readdata;
  logic [NUM_PORTS-1:0]             m_waitrequest;
  logic                             err_clear;
  logic                             err_timeout;
  logic                             err_decode;
  logic                             err_proto;
  logic [7:0]                       timeout_count;

  int n_cmp;
  int n_err;
  int strobe_cycles;

  csr_address_router #(
    .NUM_PORTS    (NUM_PORTS),
    .PORT_ADDR_W  (PORT_ADDR_W),
    .SLAVE_ADDR_W (SLAVE_ADDR_W),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .csr_clk_clk         (clk),
    .csr_clk_reset_reset (rst),
    .slave_address       (slave_address),
    .slave_read          (slave_read),
    .slave_write         (slave_write),
    .slave_writedata     (slave_writedata),
    .slave_readdata      (slave_readdata),
    .slave_waitrequest   (slave_waitrequest),
    .m_address           (m_address),
    .m_read              (m_read),
    .m_write             (m_write),
    .m_writedata         (m_writedata),
    .m_readdata          (m_readdata),
    .m_waitrequest       (m_waitrequest),
    .err_clear           (err_clear),
    .err_timeout         (err_timeout),
    .err_decode          (err_decode),
    .err_proto           (err_proto),
    .timeout_count       (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    slave_address = '0;
    slave_read    = 1'b0;
    slave_write   = 1'b0;
    slave_writedata = '0;
    m_readdata    = {32'h55AA55AA, 32'h12345678, 32'hCAFEF00D};
    m_waitrequest = 3'b111;
    err_clear     = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst_wait",   64'(slave_waitrequest), 64'h1);
    chk("rst_rdata",  64'(slave_readdata),    64'h0);
    chk("rst_strobe", 64'({m_read, m_write}), 64'h0);
    chk("rst_addr",   64'(m_address),         64'h0);
    chk("rst_wdata",  64'(m_writedata),       64'h0);
    chk("rst_errs",   64'({err_timeout, err_decode, err_proto, timeout_count}), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- read port 1, 3 stall cycles ----------------
    slave_address = 16'h0805;
    slave_read    = 1'b1;
    m_waitrequest = 3'b010;
    @(negedge clk);
    chk("rd1_strobe", 64'(m_read),            64'h2);
    chk("rd1_addr",   64'(m_address[21:11]),  64'h005);
    chk("rd1_wait_a", 64'(slave_waitrequest), 64'h1);
    // command change while stalled must be ignored
    slave_address = 16'h1010;
    @(negedge clk);
    chk("rd1_ignore", 64'({m_read, m_write}), 64'h10);
    @(negedge clk);
    chk("rd1_wait_b", 64'(slave_waitrequest), 64'h1);
    m_waitrequest = 3'b000;
    @(negedge clk);
    chk("rd1_wait_lo", 64'(slave_waitrequest), 64'h0);
    chk("rd1_rdata",   64'(slave_readdata),    64'h12345678);
    chk("rd1_drop",    64'(m_read),            64'h0);
    slave_read = 1'b0;
    @(negedge clk);
    chk("rd1_wait_hi", 64'(slave_waitrequest), 64'h1);

    // ---------------- write port 2, zero stall ----------------
    slave_address   = 16'h1010;
    slave_writedata = 32'hA5A5A5A5;
    slave_write     = 1'b1;
    @(negedge clk);
    chk("wr2_strobe", 64'({m_read, m_write}), 64'h04);
    chk("wr2_wdata",  64'(m_writedata),       64'hA5A5A5A5);
    chk("wr2_addr",   64'(m_address[32:22]),  64'h010);
    chk("wr2_hold1",  64'(m_address[21:11]),  64'h005);
    chk("wr2_wait_a", 64'(slave_waitrequest), 64'h1);
    @(negedge clk);
    chk("wr2_wait_lo", 64'(slave_waitrequest), 64'h0);
    chk("wr2_rdata",   64'(slave_readdata),    64'h0);
    chk("wr2_drop",    64'(m_write),           64'h0);
    slave_write = 1'b0;
    @(negedge clk);
    chk("wr2_wait_hi", 64'(slave_waitrequest), 64'h1);
    chk("wr2_hold_wd", 64'(m_writedata),       64'hA5A5A5A5);

    // ---------------- decode error ----------------
    slave_address = 16'h1800;
    slave_read    = 1'b1;
    @(negedge clk);
    chk("dec_strobe", 64'({m_read, m_write}), 64'h0);
    chk("dec_wait",   64'(slave_waitrequest), 64'h0);
    chk("dec_rdata",  64'(slave_readdata),    64'hBADADD00);
    chk("dec_flag",   64'(err_decode),        64'h1);
    slave_read = 1'b0;
    @(negedge clk);
    chk("dec_wait_hi", 64'(slave_waitrequest), 64'h1);

    // ---------------- timeout on port 0 ----------------
    slave_address = 16'h0003;
    slave_read    = 1'b1;
    m_waitrequest = 3'b001;
    strobe_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m_read == 3'b001) strobe_cycles++;
    end
    chk("to_strobe_cycles", 64'(strobe_cycles), 64'd16);
    @(negedge clk);
    chk("to_drop",   64'(m_read),            64'h0);
    chk("to_wait",   64'(slave_waitrequest), 64'h0);
    chk("to_rdata",  64'(slave_readdata),    64'hDEADC0DE);
    chk("to_flag",   64'(err_timeout),       64'h1);
    chk("to_count",  64'(timeout_count),     64'h1);
    chk("to_sticky_dec", 64'(err_decode),    64'h1);
    slave_read    = 1'b0;
    m_waitrequest = 3'b000;
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("clr_all", 64'({err_timeout, err_decode, err_proto, timeout_count}), 64'h0);

    // ---------------- read+write together ----------------
    slave_address   = 16'h0807;
    slave_writedata = 32'h0BADF00D;
    slave_read      = 1'b1;
    slave_write     = 1'b1;
    @(negedge clk);
    chk("pro_strobe", 64'({m_read, m_write}), 64'h02);
    chk("pro_wdata",  64'(m_writedata),       64'h0BADF00D);
    chk("pro_flag",   64'(err_proto),         64'h1);
    @(negedge clk);
    chk("pro_wait_lo", 64'(slave_waitrequest), 64'h0);
    slave_read  = 1'b0;
    slave_write = 1'b0;
    @(negedge clk);

    // ---------------- reset during ISSUE ----------------
    slave_address = 16'h1020;
    slave_read    = 1'b1;
    m_waitrequest = 3'b100;
    @(negedge clk);
    chk("rst_mid_strobe_pre", 64'(m_read), 64'h4);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobe", 64'({m_read, m_write}), 64'h0);
    chk("rst_mid_wait",   64'(slave_waitrequest), 64'h1);
    slave_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_waitrequest = 3'b000;
    @(negedge clk);
    chk("rst_mid_idle_wait", 64'(slave_waitrequest), 64'h1);

    // ---------------- normal transaction after reset ----------------
    slave_address = 16'h0001;
    slave_read    = 1'b1;
    @(negedge clk);
    chk("post_strobe", 64'(m_read), 64'h1);
    @(negedge clk);
    chk("post_wait_lo", 64'(slave_waitrequest), 64'h0);
    chk("post_rdata",   64'(slave_readdata),    64'hCAFEF00D);
    slave_read = 1'b0;
    @(negedge clk);
    chk("post_wait_hi", 64'(slave_waitrequest), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
